// File: rtl/tl_pkg.sv
// Shared lamp encodings, fault codes and monitor states for the traffic conflict monitor.
package tl_pkg;

    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    typedef enum logic [2:0] {
        NONE         = 3'd0,
        ILLEGAL      = 3'd1,
        CONFLICT     = 3'd2,
        PED_CONFLICT = 3'd3,
        SEQ          = 3'd4,
        SHORT_YEL    = 3'd5
    } fault_code_t;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        FAULT   = 2'd1,
        RECOVER = 2'd2
    } mon_state_t;

    // True for one of the three defined one-hot lamp values.
    function automatic logic is_legal(input logic [2:0] l);
        return (l == RED) || (l == YEL) || (l == GRN);
    endfunction

    // True for a legal lamp value that is not red.
    function automatic logic is_non_red(input logic [2:0] l);
        return is_legal(l) && (l != RED);
    endfunction

endpackage

// File: rtl/tl_head_checker.sv
// Per-head history: previous lamp, consecutive-yellow counter, sequence and short-yellow checks.
module tl_head_checker
    import tl_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] head,
    input  logic       prev_valid,
    input  logic       enable,
    output logic       seq_err,
    output logic       short_yel_err
);

    localparam int unsigned YW = $clog2(MIN_YELLOW + 1);

    logic [2:0]    prev_q;
    logic [YW-1:0] yel_cnt;

    // Track last lamp and saturating yellow run length while monitoring; forget history otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= RED;
            yel_cnt <= '0;
        end else if (enable) begin
            prev_q <= head;
            if (head == YEL) begin
                if (yel_cnt != YW'(MIN_YELLOW)) begin
                    yel_cnt <= yel_cnt + YW'(1);
                end
            end else begin
                yel_cnt <= '0;
            end
        end else begin
            yel_cnt <= '0;
        end
    end

    // Illegal transitions are only meaningful once a previous monitored value exists.
    always_comb begin
        seq_err       = 1'b0;
        short_yel_err = 1'b0;
        if (enable && prev_valid) begin
            seq_err = ((prev_q == GRN) && (head == RED)) ||
                      ((prev_q == RED) && (head == YEL)) ||
                      ((prev_q == YEL) && (head == GRN));
            short_yel_err = (prev_q == YEL) && (head == RED) &&
                            (yel_cnt < YW'(MIN_YELLOW));
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage behind traffic_light: checks lamp buses, passes them through one cycle late,
// and on the first fault flashes red until cleared, then holds all-red before resuming.
// Optional macro FAULT_COUNT_EN adds the saturating fault_cnt output.
module traffic_conflict_monitor
    import tl_pkg::*;
#(
    parameter int unsigned MIN_YELLOW  = 3,
    parameter int unsigned FLASH_HALF  = 4,
    parameter int unsigned ALL_RED_CYC = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ns,
    input  logic [2:0] ew,
    input  logic [2:0] p_ns,
    input  logic [2:0] p_ew,
    input  logic       fault_clr,
    output logic [2:0] lamp_ns,
    output logic [2:0] lamp_ew,
    output logic [2:0] lamp_p_ns,
    output logic [2:0] lamp_p_ew,
    output logic       fault,
    output logic [2:0] fault_code
`ifdef FAULT_COUNT_EN
    ,
    output logic [7:0] fault_cnt
`endif
);

    localparam int unsigned FLASH_PER = 2 * FLASH_HALF;
    localparam int unsigned CNT_MAX   = (FLASH_PER > ALL_RED_CYC) ? FLASH_PER : ALL_RED_CYC;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    mon_state_t       state;
    mon_state_t       state_nxt;
    fault_code_t      code_c;
    fault_code_t      code_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] flash_nxt_c;
    logic [2:0]       flash_lamp_c;
    logic             rec_done_c;
    logic             prev_valid;
    logic             chk_en_c;
    logic             ns_seq_c;
    logic             ns_short_c;
    logic             ew_seq_c;
    logic             ew_short_c;

    assign chk_en_c   = (state == MONITOR);
    assign fault_code = code_q;

    tl_head_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ns_chk (
        .clk           (clk),
        .rst           (rst),
        .head          (ns),
        .prev_valid    (prev_valid),
        .enable        (chk_en_c),
        .seq_err       (ns_seq_c),
        .short_yel_err (ns_short_c)
    );

    tl_head_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ew_chk (
        .clk           (clk),
        .rst           (rst),
        .head          (ew),
        .prev_valid    (prev_valid),
        .enable        (chk_en_c),
        .seq_err       (ew_seq_c),
        .short_yel_err (ew_short_c)
    );

    // Priority encode of all checks; lowest code wins.
    always_comb begin
        code_c = NONE;
        if (!is_legal(ns) || !is_legal(ew) || !is_legal(p_ns) || !is_legal(p_ew)) begin
            code_c = ILLEGAL;
        end else if (is_non_red(ns) && is_non_red(ew)) begin
            code_c = CONFLICT;
        end else if ((is_non_red(p_ns) && is_non_red(ew)) ||
                     (is_non_red(p_ew) && is_non_red(ns))) begin
            code_c = PED_CONFLICT;
        end else if (ns_seq_c || ew_seq_c) begin
            code_c = SEQ;
        end else if (ns_short_c || ew_short_c) begin
            code_c = SHORT_YEL;
        end
    end

    // Flash phase counter wraps over one full on/off period; recover ends after its last cycle.
    always_comb begin
        flash_nxt_c  = (cnt == CNT_W'(FLASH_PER - 1)) ? '0 : cnt + CNT_W'(1);
        flash_lamp_c = (flash_nxt_c < CNT_W'(FLASH_HALF)) ? RED : DARK;
        rec_done_c   = (cnt == CNT_W'(ALL_RED_CYC - 1));
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            MONITOR: if (code_c != NONE) state_nxt = FAULT;
            FAULT:   if (fault_clr)      state_nxt = RECOVER;
            RECOVER: if (rec_done_c)     state_nxt = MONITOR;
            default: state_nxt = MONITOR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MONITOR;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered lamp drive, fault flag/code, phase counter and history-valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lamp_ns    <= RED;
            lamp_ew    <= RED;
            lamp_p_ns  <= RED;
            lamp_p_ew  <= RED;
            fault      <= 1'b0;
            code_q     <= NONE;
            cnt        <= '0;
            prev_valid <= 1'b0;
        end else begin
            case (state)
                MONITOR: begin
                    if (code_c != NONE) begin
                        // Offending inputs never reach the lamps; flash starts with red.
                        fault     <= 1'b1;
                        code_q    <= code_c;
                        cnt       <= '0;
                        lamp_ns   <= RED;
                        lamp_ew   <= RED;
                        lamp_p_ns <= RED;
                        lamp_p_ew <= RED;
                    end else begin
                        lamp_ns    <= ns;
                        lamp_ew    <= ew;
                        lamp_p_ns  <= p_ns;
                        lamp_p_ew  <= p_ew;
                        prev_valid <= 1'b1;
                    end
                end
                FAULT: begin
                    lamp_p_ns <= RED;
                    lamp_p_ew <= RED;
                    if (fault_clr) begin
                        fault   <= 1'b0;
                        cnt     <= '0;
                        lamp_ns <= RED;
                        lamp_ew <= RED;
                    end else begin
                        cnt     <= flash_nxt_c;
                        lamp_ns <= flash_lamp_c;
                        lamp_ew <= flash_lamp_c;
                    end
                end
                RECOVER: begin
                    // Lamps stay red through the exit edge so unchecked inputs are never driven.
                    lamp_ns   <= RED;
                    lamp_ew   <= RED;
                    lamp_p_ns <= RED;
                    lamp_p_ew <= RED;
                    if (rec_done_c) begin
                        code_q     <= NONE;
                        prev_valid <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FAULT_COUNT_EN
    // Saturating count of MONITOR->FAULT entries; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_cnt <= '0;
        end else if ((state == MONITOR) && (code_c != NONE) && (fault_cnt != 8'hFF)) begin
            fault_cnt <= fault_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed vector table, hand sequences, then random
// stimulus against a history-based reference model.
module tb_traffic_conflict_monitor;
    import tl_pkg::*;

    localparam int unsigned MIN_YELLOW  = 3;
    localparam int unsigned FLASH_HALF  = 4;
    localparam int unsigned ALL_RED_CYC = 6;
    localparam int unsigned N_RAND      = 3000;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ns, ew, p_ns, p_ew;
    logic       fault_clr;
    logic [2:0] lamp_ns, lamp_ew, lamp_p_ns, lamp_p_ew;
    logic       fault;
    logic [2:0] fault_code;
`ifdef FAULT_COUNT_EN
    logic [7:0] fault_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    traffic_conflict_monitor #(
        .MIN_YELLOW  (MIN_YELLOW),
        .FLASH_HALF  (FLASH_HALF),
        .ALL_RED_CYC (ALL_RED_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ns         (ns),
        .ew         (ew),
        .p_ns       (p_ns),
        .p_ew       (p_ew),
        .fault_clr  (fault_clr),
        .lamp_ns    (lamp_ns),
        .lamp_ew    (lamp_ew),
        .lamp_p_ns  (lamp_p_ns),
        .lamp_p_ew  (lamp_p_ew),
        .fault      (fault),
        .fault_code (fault_code)
`ifdef FAULT_COUNT_EN
        ,
        .fault_cnt  (fault_cnt)
`endif
    );

    // {lamp_ns, lamp_ew, lamp_p_ns, lamp_p_ew, fault, fault_code}
    function automatic logic [15:0] pk(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c, input logic [2:0] d,
                                       input logic f, input logic [2:0] code);
        return {a, b, c, d, f, code};
    endfunction

    function automatic logic [15:0] outs();
        return pk(lamp_ns, lamp_ew, lamp_p_ns, lamp_p_ew, fault, fault_code);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                         input logic [2:0] d, input logic clr);
        ns = a; ew = b; p_ns = c; p_ew = d; fault_clr = clr;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  ns, ew, pn, pe;
        logic        clr;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                       input logic [2:0] d, input logic clr, input logic [15:0] exp);
        vec_t v;
        v.ns = a; v.ew = b; v.pn = c; v.pe = d; v.clr = clr; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Clear pulse then the rest of the all-red hold; code clears as recovery ends.
    task automatic add_recover(input logic [2:0] code);
        add(RED, RED, RED, RED, 1'b1, pk(RED, RED, RED, RED, 1'b0, code));
        for (int i = 1; i < int'(ALL_RED_CYC); i++)
            add(RED, RED, RED, RED, 1'b0, pk(RED, RED, RED, RED, 1'b0, code));
        add(RED, RED, RED, RED, 1'b0, pk(RED, RED, RED, RED, 1'b0, 3'd0));
    endtask

    // ---------------- reference model ----------------
    int          m_mode;   // 0 watching, 1 flashing, 2 all-red hold
    int          m_t;      // cycles since entering current fault/hold mode
    logic [2:0]  m_code;
    int          m_fcnt;
    logic [2:0]  h_ns[$];
    logic [2:0]  h_ew[$];
    logic [15:0] m_exp;

    function automatic bit legal(input logic [2:0] x);
        return (x == 3'b100) || (x == 3'b010) || (x == 3'b001);
    endfunction

    function automatic bit nonred(input logic [2:0] x);
        return legal(x) && (x != 3'b100);
    endfunction

    // Sequence/short-yellow verdict for one head given its watched history.
    function automatic int head_code(input logic [2:0] cur, input logic [2:0] h[$]);
        logic [2:0] p;
        int run;
        if (h.size() == 0) return 0;
        p = h[h.size()-1];
        if ((p == GRN && cur == RED) || (p == RED && cur == YEL) || (p == YEL && cur == GRN))
            return 4;
        run = 0;
        for (int i = h.size() - 1; i >= 0; i--) begin
            if (h[i] != YEL) break;
            run++;
        end
        if (p == YEL && cur == RED && run < int'(MIN_YELLOW)) return 5;
        return 0;
    endfunction

    function automatic int ref_code(input logic [2:0] a, input logic [2:0] b,
                                    input logic [2:0] c, input logic [2:0] d);
        int hn, he;
        if (!legal(a) || !legal(b) || !legal(c) || !legal(d)) return 1;
        if (nonred(a) && nonred(b)) return 2;
        if ((nonred(c) && nonred(b)) || (nonred(d) && nonred(a))) return 3;
        hn = head_code(a, h_ns);
        he = head_code(b, h_ew);
        if (hn == 4 || he == 4) return 4;
        if (hn == 5 || he == 5) return 5;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_code = 3'd0; m_fcnt = 0;
        h_ns.delete(); h_ew.delete();
        m_exp = pk(RED, RED, RED, RED, 1'b0, 3'd0);
    endtask

    // Predicts outputs after the coming edge for the given inputs.
    task automatic model_step(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                              input logic [2:0] d, input logic clr);
        int code;
        logic [2:0] v;
        case (m_mode)
            0: begin
                code = ref_code(a, b, c, d);
                if (code != 0) begin
                    m_mode = 1; m_t = 0; m_code = 3'(code);
                    if (m_fcnt < 255) m_fcnt++;
                    m_exp = pk(RED, RED, RED, RED, 1'b1, m_code);
                end else begin
                    h_ns.push_back(a); h_ew.push_back(b);
                    if (h_ns.size() > 8) begin void'(h_ns.pop_front()); void'(h_ew.pop_front()); end
                    m_exp = pk(a, b, c, d, 1'b0, 3'd0);
                end
            end
            1: begin
                if (clr) begin
                    m_mode = 2; m_t = 0;
                    m_exp = pk(RED, RED, RED, RED, 1'b0, m_code);
                end else begin
                    m_t++;
                    v = (((m_t / int'(FLASH_HALF)) % 2) == 0) ? RED : 3'b000;
                    m_exp = pk(v, v, RED, RED, 1'b1, m_code);
                end
            end
            default: begin
                m_t++;
                if (m_t == int'(ALL_RED_CYC)) begin
                    m_mode = 0; m_code = 3'd0;
                    h_ns.delete(); h_ew.delete();
                end
                m_exp = pk(RED, RED, RED, RED, 1'b0, m_code);
            end
        endcase
    endtask

    function automatic logic [2:0] rnd_lamp(input logic [2:0] cur);
        int r;
        logic [2:0] x;
        if ($urandom_range(0, 3) != 0) return cur;
        r = int'($urandom_range(0, 19));
        if (r == 0) begin
            x = 3'($urandom_range(0, 7));
            return x;
        end
        if (r < 9) return RED;
        if (r < 14) return YEL;
        return GRN;
    endfunction

    initial begin
        logic [2:0] rn, re, rpn, rpe;
        logic rc;

        rst = 1'b0;
        ns = RED; ew = RED; p_ns = RED; p_ew = RED; fault_clr = 1'b0;
        model_reset();

        // Table: legal cycle, conflict + flash, clear/recover, short yellow, bad sequence, illegal.
        add(GRN, RED, RED, RED, 1'b0, pk(GRN, RED, RED, RED, 1'b0, 3'd0));
        for (int i = 0; i < 3; i++)
            add(YEL, RED, RED, RED, 1'b0, pk(YEL, RED, RED, RED, 1'b0, 3'd0));
        add(RED, GRN, RED, RED, 1'b0, pk(RED, GRN, RED, RED, 1'b0, 3'd0));
        for (int i = 0; i < 3; i++)
            add(RED, YEL, RED, RED, 1'b0, pk(RED, YEL, RED, RED, 1'b0, 3'd0));
        add(RED, RED, RED, RED, 1'b0, pk(RED, RED, RED, RED, 1'b0, 3'd0));
        add(GRN, GRN, RED, RED, 1'b0, pk(RED, RED, RED, RED, 1'b1, 3'd2));
        for (int i = 1; i <= 8; i++) begin
            if (i < 4 || i == 8)
                add(GRN, GRN, RED, RED, 1'b0, pk(RED, RED, RED, RED, 1'b1, 3'd2));
            else
                add(GRN, GRN, RED, RED, 1'b0, pk(3'b000, 3'b000, RED, RED, 1'b1, 3'd2));
        end
        add_recover(3'd2);
        add(GRN, RED, RED, RED, 1'b0, pk(GRN, RED, RED, RED, 1'b0, 3'd0));
        add(YEL, RED, RED, RED, 1'b0, pk(YEL, RED, RED, RED, 1'b0, 3'd0));
        add(YEL, RED, RED, RED, 1'b0, pk(YEL, RED, RED, RED, 1'b0, 3'd0));
        add(RED, RED, RED, RED, 1'b0, pk(RED, RED, RED, RED, 1'b1, 3'd5));
        add_recover(3'd5);
        add(GRN, RED, RED, RED, 1'b0, pk(GRN, RED, RED, RED, 1'b0, 3'd0));
        add(RED, RED, RED, RED, 1'b0, pk(RED, RED, RED, RED, 1'b1, 3'd4));
        add_recover(3'd4);
        add(3'b011, GRN, RED, RED, 1'b0, pk(RED, RED, RED, RED, 1'b1, 3'd1));

        #12;
        check("reset_outputs", outs(), pk(RED, RED, RED, RED, 1'b0, 3'd0));
`ifdef FAULT_COUNT_EN
        check("reset_fault_cnt", 16'(fault_cnt), 16'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].ns, tbl[i].ew, tbl[i].pn, tbl[i].pe, tbl[i].clr);
            check($sformatf("table_row_%0d", i), outs(), tbl[i].exp);
        end

        // Two more flash-on cycles, then asynchronous reset mid-flash.
        apply(RED, RED, RED, RED, 1'b0);
        check("flash_hold_1", outs(), pk(RED, RED, RED, RED, 1'b1, 3'd1));
        apply(RED, RED, RED, RED, 1'b0);
        check("flash_hold_2", outs(), pk(RED, RED, RED, RED, 1'b1, 3'd1));
        #3 rst = 1'b0;
        #1;
        check("async_reset_mid_flash", outs(), pk(RED, RED, RED, RED, 1'b0, 3'd0));
        @(posedge clk); #1;
        rst = 1'b1;

        // Pedestrian conflict, clear ignored in MONITOR, and fault counting over rounds.
        apply(GRN, RED, RED, GRN, 1'b0);
        check("ped_conflict", outs(), pk(RED, RED, RED, RED, 1'b1, 3'd3));
        apply(RED, RED, RED, RED, 1'b1);
        for (int i = 1; i < int'(ALL_RED_CYC); i++) apply(RED, RED, RED, RED, 1'b0);
        check("recover_last_cycle", outs(), pk(RED, RED, RED, RED, 1'b0, 3'd3));
        apply(RED, RED, RED, RED, 1'b0);
        check("recover_exit", outs(), pk(RED, RED, RED, RED, 1'b0, 3'd0));
        apply(GRN, RED, RED, RED, 1'b1);
        check("clr_ignored_in_monitor", outs(), pk(GRN, RED, RED, RED, 1'b0, 3'd0));
        apply(GRN, GRN, RED, RED, 1'b0);
        check("second_fault", outs(), pk(RED, RED, RED, RED, 1'b1, 3'd2));
        apply(RED, RED, RED, RED, 1'b1);
        for (int i = 0; i < int'(ALL_RED_CYC); i++) apply(RED, RED, RED, RED, 1'b0);
        apply(YEL, RED, RED, RED, 1'b0);
        check("first_cycle_no_seq_check", outs(), pk(YEL, RED, RED, RED, 1'b0, 3'd0));
        apply(RED, RED, RED, RED, 1'b0);
        check("third_fault_short_yel", outs(), pk(RED, RED, RED, RED, 1'b1, 3'd5));
`ifdef FAULT_COUNT_EN
        check("fault_cnt_three", 16'(fault_cnt), 16'd3);
`endif

        // Random stimulus against the reference model.
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        rn = RED; re = RED; rpn = RED; rpe = RED;
        for (int i = 0; i < int'(N_RAND); i++) begin
            rn  = rnd_lamp(rn);
            re  = rnd_lamp(re);
            rpn = rnd_lamp(rpn);
            rpe = rnd_lamp(rpe);
            rc  = ($urandom_range(0, 5) == 0);
            model_step(rn, re, rpn, rpe, rc);
            apply(rn, re, rpn, rpe, rc);
            check($sformatf("random_%0d", i), outs(), m_exp);
`ifdef FAULT_COUNT_EN
            check($sformatf("random_cnt_%0d", i), 16'(fault_cnt), 16'(m_fcnt));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
Safety stage directly downstream of traffic_light. It consumes the four lamp buses ns, ew, p_ns and p_ew every cycle and checks them for illegal encodings, conflicting greens, bad sequencing and short yellows. With no fault it passes the lamps through to the drivers, one cycle late. On the first fault it latches a code, forces a fail-safe flashing-red pattern until an operator clear, then holds all-red before resuming pass-through.

Parameters:
MIN_YELLOW, 3, minimum consecutive yellow cycles on a vehicle head before red
FLASH_HALF, 4, cycles per half-period of fault flash (on, then off)
ALL_RED_CYC, 6, cycles of steady all-red in RECOVER before returning to MONITOR

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
ns  input  3  north-south vehicle head from traffic_light
ew  input  3  east-west vehicle head
p_ns  input  3  north-south pedestrian head
p_ew  input  3  east-west pedestrian head
fault_clr  input  1  operator clear, single-cycle pulse
lamp_ns  output  3  driven NS vehicle lamps
lamp_ew  output  3  driven EW vehicle lamps
lamp_p_ns  output  3  driven NS pedestrian lamps
lamp_p_ew  output  3  driven EW pedestrian lamps
fault  output  1  high while state is FAULT
fault_code  output  3  latched first-fault code; 0 = none
fault_cnt  output  8  present only with FAULT_COUNT_EN

Behaviour:
- Lamp encoding (decided): RED=3'b100, YEL=3'b010, GRN=3'b001. Any other value is illegal.
- "Non-red" means any legal value other than RED.
- Reset (rst low, asynchronous):
  - all four lamp outputs = RED; fault=0; fault_code=0; fault_cnt=0.
  - state=MONITOR; prev_valid=0; yellow counters=0.
- FSM states:
  - MONITOR: checks active. Outputs are the registered inputs (1-cycle latency).
  - FAULT: vehicle lamps toggle between RED for FLASH_HALF cycles and 3'b000 for FLASH_HALF cycles, starting with RED. Pedestrian lamps steady RED.
  - RECOVER: all lamps steady RED for ALL_RED_CYC cycles, then MONITOR with prev_valid=0.
- Checks are evaluated combinationally in MONITOR on the current inputs and the previous-cycle registers. Fault codes:
  - 1: illegal encoding on any of the four inputs.
  - 2: ns and ew both non-red.
  - 3: p_ns non-red while ew non-red, or p_ew non-red while ns non-red.
  - 4: vehicle sequence violation (GRN->RED, RED->YEL or YEL->GRN). Evaluated only when prev_valid=1.
  - 5: YEL->RED with the yellow counter < MIN_YELLOW.
- Several checks true in the same cycle: the lowest code wins.
- Fault detected in cycle t:
  - at edge t+1: state=FAULT, fault=1, fault_code latched, first flash phase begins.
  - the offending inputs are never driven to the lamps.
- In FAULT, further faults are ignored and fault_code holds.
- fault_clr:
  - in FAULT: move to RECOVER on the next edge; fault=0; fault_code holds until RECOVER exits, then clears to 0.
  - in MONITOR or RECOVER: ignored.
- Yellow counter, one per vehicle head:
  - increments while the head is YEL, saturating at MIN_YELLOW.
  - clears on any non-YEL value.
- prev_valid goes to 1 after the first MONITOR cycle.
- Flash and recover counters: width $clog2(max(2*FLASH_HALF, ALL_RED_CYC)+1); reload to 0 on each state entry.
- rst low mid-FAULT or mid-RECOVER: immediate return to reset values.

Optional Feature:
- FAULT_COUNT_EN defined:
  - fault_cnt port exists.
  - increments by 1 on each MONITOR->FAULT entry, saturating at 255.
  - cleared only by rst; fault_clr does not clear it.
- FAULT_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tl_pkg:
  - lamp localparams RED/YEL/GRN.
  - fault_code_t enum (NONE, ILLEGAL, CONFLICT, PED_CONFLICT, SEQ, SHORT_YEL).
  - mon_state_t enum (MONITOR, FAULT, RECOVER).
- Sub-module tl_head_checker, instantiated for ns and ew:
  - contains the prev register, yellow counter and the sequence/short-yellow checks.
  - inputs: head, prev_valid, enable. Outputs: seq_err, short_yel_err.
- The top holds the FSM, cross-head conflict checks, priority encode and output muxing.

Test Plan:
- Reset, then a legal cycle: ns=GRN,ew=RED -> ns=YEL x3 -> ns=RED,ew=GRN. Expect lamps to match the inputs one cycle later, fault=0, fault_code=0 throughout.
- Drive ns=GRN and ew=GRN together. Expect fault=1 next edge, fault_code=2, lamp_ns/lamp_ew alternating 100/000 every 4 cycles, pedestrian lamps steady 100.
- Drive ns YEL for 2 cycles then RED -> fault_code=5. Drive ns GRN->RED directly -> fault_code=4.
- Drive ns=3'b011 and ew=GRN in the same cycle (codes 1 and 2 both true). Expect fault_code=1.
- In FAULT pulse fault_clr. Expect fault=0 next edge, 6 cycles of all-100 lamps, then pass-through resumes and fault_code reads 0.
- Drive rst low mid-flash. Expect lamps=100 and fault=0 immediately. With FAULT_COUNT_EN, 3 fault/clear rounds give fault_cnt=3.
